// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, opcode fields, state encodings and queue entry type for fetch_ctrl.
// Macro-level defines live here too so every file that imports the package sees them.
`ifndef FETCH_CTRL_DEFINES
`define FETCH_CTRL_DEFINES
`define WIDTH      32
`define BR         6'h04
`define OPC_HI     31
`define OPC_LO     26
`define FETCH_IDLE 2'd0
`define FETCH_RUN  2'd1
`define FETCH_HALT 2'd2
`define FETCH_FLT  2'd3
`endif

package fetch_ctrl_pkg;
    localparam int         WIDTH  = `WIDTH;
    localparam int         OPC_HI = `OPC_HI;
    localparam int         OPC_LO = `OPC_LO;
    localparam logic [5:0] OP_BR  = `BR;

    typedef enum logic [1:0] {
        ST_IDLE  = `FETCH_IDLE,
        ST_RUN   = `FETCH_RUN,
        ST_HALT  = `FETCH_HALT,
        ST_FAULT = `FETCH_FLT
    } fetch_state_e;

    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [31:0]      pc;
        logic             pred;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory read port plus decode-side valid/ready handshake of the fetch sequencer.
interface fetch_ctrl_if;
    logic [31:0]                     pc_o;
    logic [fetch_ctrl_pkg::WIDTH-1:0] inst_i;
    logic [fetch_ctrl_pkg::WIDTH-1:0] inst_o;
    logic [31:0]                     inst_pc_o;
    logic                            inst_valid_o;
    logic                            inst_ready_i;
    logic                            pred_taken_o;

    modport master (output pc_o, input inst_i, output inst_o, output inst_pc_o,
                    output inst_valid_o, input inst_ready_i, output pred_taken_o);
    modport slave  (input pc_o, output inst_i, input inst_o, input inst_pc_o,
                    input inst_valid_o, output inst_ready_i, input pred_taken_o);
endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: 2-entry FIFO of {inst, pc, pred}; pure storage, all policy lives in fetch_ctrl.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t mem [DEPTH];
    logic         wptr, rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= '0;
        end else if (flush) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rptr];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and fetch state machine feeding decode through fetch_buf.
// Optional static backward-taken branch prediction under FETCH_PREDICT_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          MEM_DEPTH = 16,
    parameter logic [31:0] BOOT_PC   = 32'd0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         halt_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    fetch_ctrl_if.master bus,
    output logic         fault_o,
    output logic [1:0]   state_o
);
    fetch_state_e state_q;
    logic [31:0]  pc_q, next_pc;
    logic [1:0]   count;
    logic         in_range, pop, flush, fetch, pred_push;
    fetch_entry_t wdata, head;

    assign in_range = pc_q < 32'(MEM_DEPTH);
    assign pop      = (count != 2'd0) && bus.inst_ready_i;
    assign flush    = redirect_i && (state_q != ST_IDLE);
    assign fetch    = (state_q == ST_RUN) && !halt_i && in_range && !redirect_i &&
                      ((count < 2'(BUF_DEPTH)) || pop);

`ifdef FETCH_PREDICT_EN
    logic taken, pred_next_q;
    assign taken     = (bus.inst_i[OPC_HI:OPC_LO] == OP_BR) && bus.inst_i[15];
    assign next_pc   = taken ? pc_q + {{16{bus.inst_i[15]}}, bus.inst_i[15:0]} : pc_q + 32'd1;
    assign pred_push = pred_next_q;

    // The tag belongs to the word fetched after a predicted branch, not the branch itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           pred_next_q <= 1'b0;
        else if (flush || state_q == ST_IDLE) pred_next_q <= 1'b0;
        else if (fetch)                       pred_next_q <= taken;
    end
`else
    assign next_pc   = pc_q + 32'd1;
    assign pred_push = 1'b0;
`endif

    assign wdata = {bus.inst_i, pc_q, pred_push};

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fetch),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= BOOT_PC;
        end else if (state_q == ST_IDLE) begin
            if (start_i) begin
                state_q <= ST_RUN;
                pc_q    <= BOOT_PC;
            end
        end else if (redirect_i) begin
            // Redirect wins everywhere; target range is checked once back in RUN.
            pc_q    <= redirect_pc_i;
            state_q <= halt_i ? ST_HALT : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_i)         state_q <= ST_HALT;
                    else if (!in_range) state_q <= ST_FAULT;
                    else if (fetch)     pc_q    <= next_pc;
                end
                ST_HALT: if (!halt_i) state_q <= ST_RUN;
                default: ;
            endcase
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.inst_o       = head.inst;
    assign bus.inst_pc_o    = head.pc;
    assign bus.pred_taken_o = head.pred;
    assign bus.inst_valid_o = (count != 2'd0);
    assign fault_o          = (state_q == ST_FAULT);
    assign state_o          = state_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized run against a queue model.
module tb_fetch_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_i = 1'b0, halt_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        fault_o;
    logic [1:0]  state_o;
    logic [31:0] mem [DEPTH];
    int          n_tests = 0, n_fail = 0;

    fetch_ctrl_if bus();

    fetch_ctrl #(.MEM_DEPTH(DEPTH), .BOOT_PC(32'd0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .bus(bus), .fault_o(fault_o), .state_o(state_o)
    );

    always #5 clk = ~clk;
    assign bus.inst_i = (bus.pc_o < DEPTH) ? mem[bus.pc_o[3:0]] : 32'd0;

    // Reference model: state number, PC and a queue of fetched entries.
    typedef struct { logic [31:0] inst; logic [31:0] pc; logic pred; } ent_t;
    ent_t        mq[$];
    int          m_st;
    logic [31:0] m_pc;
    logic        m_pflag;

    function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [31:0] w,
                                           output logic taken);
        taken = 1'b0;
`ifdef FETCH_PREDICT_EN
        taken = (w[31:26] == 6'h04) && w[15];
        if (taken) return pc + {{16{w[15]}}, w[15:0]};
`endif
        return pc + 32'd1;
    endfunction

    task automatic model_step();
        ent_t e; logic pop, tk; int sz; logic [31:0] w;
        sz  = mq.size();
        pop = (sz > 0) && bus.inst_ready_i;
        w   = (m_pc < DEPTH) ? mem[m_pc[3:0]] : 32'd0;
        if (m_st == 0) begin
            if (start_i) begin m_st = 1; m_pc = 32'd0; end
        end else if (redirect_i) begin
            mq.delete(); m_pc = redirect_pc_i; m_st = halt_i ? 2 : 1; m_pflag = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_st == 1) begin
                if (halt_i) m_st = 2;
                else if (m_pc >= DEPTH) m_st = 3;
                else if (sz < 2 || pop) begin
                    e.inst = w; e.pc = m_pc; e.pred = m_pflag;
                    mq.push_back(e);
                    m_pc = m_next(m_pc, w, tk);
                    m_pflag = tk;
                end
            end else if (m_st == 2 && !halt_i) m_st = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start_i = 1'b0; halt_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'd0; bus.inst_ready_i = 1'b0;
        #4;
        rst_n = 1'b1;
        mq.delete(); m_st = 0; m_pc = 32'd0; m_pflag = 1'b0;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] prog_word(input int i);
        case (i)
            0, 1, 2: return {6'h01, 5'(i), 5'd0, 16'(i + 7)};
            3:       return {6'h02, 5'd1, 5'd2, 16'd0};
            4:       return {6'h03, 5'd1, 5'd3, 16'd0};
            5:       return {6'h04, 10'd0, 16'hFFFE};
            default: return 32'd0;
        endcase
    endfunction

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) mem[i] = prog_word(i);
    endtask

    task automatic start_run(input logic rdy);
        load_prog();
        bus.inst_ready_i = rdy;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({state_o, fault_o, bus.inst_valid_o, bus.pred_taken_o} !== 5'd0 ||
            bus.pc_o !== 32'd0 || bus.inst_o !== 32'd0 || bus.inst_pc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d fault=%b valid=%b pc=%0h inst=%0h ipc=%0h, required all 0",
                     state_o, fault_o, bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.inst_pc_o);
        end
        do_reset();
    endtask

    task automatic test_program();
        do_reset();
        start_run(1'b1);
        n_tests++;
        if (state_o !== 2'd1 || bus.inst_valid_o !== 1'b0 || bus.pc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL prog_start: state=%0d valid=%b pc=%0d, required 1/0/0", state_o, bus.inst_valid_o, bus.pc_o);
        end
        tick();
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'(k) ||
                bus.inst_o !== prog_word(k) || fault_o !== 1'b0) begin
                n_fail++;
                $display("FAIL prog_seq[%0d]: valid=%b ipc=%0d inst=%0h fault=%b, required 1/%0d/%0h/0",
                         k, bus.inst_valid_o, bus.inst_pc_o, bus.inst_o, fault_o, k, prog_word(k));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start_run(1'b0);
        repeat (5) tick();
        n_tests++;
        if (bus.pc_o !== 32'd2 || bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL bp_hold: pc=%0d valid=%b ipc=%0d, required 2/1/0", bus.pc_o, bus.inst_valid_o, bus.inst_pc_o);
        end
        bus.inst_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'(k)) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: valid=%b ipc=%0d, required 1/%0d", k, bus.inst_valid_o, bus.inst_pc_o, k);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        int exp_pc [3] = '{3, 4, 5};
        do_reset();
        start_run(1'b1);
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus.inst_valid_o && bus.inst_pc_o == 32'd4) found = 1;
            else tick();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL redir_wait: head pc 4 not seen within 20 cycles");
        end
        bus.inst_ready_i = 1'b0;
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'd3;
        tick();
        redirect_i = 1'b0; bus.inst_ready_i = 1'b1;
        n_tests++;
        if (bus.inst_valid_o !== 1'b0 || bus.pc_o !== 32'd3) begin
            n_fail++;
            $display("FAIL redir_flush: valid=%b pc=%0d, required 0/3", bus.inst_valid_o, bus.pc_o);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'(exp_pc[k]) || bus.pred_taken_o !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_seq[%0d]: valid=%b ipc=%0d pred=%b, required 1/%0d/0",
                         k, bus.inst_valid_o, bus.inst_pc_o, bus.pred_taken_o, exp_pc[k]);
            end
            tick();
        end
    endtask

`ifdef FETCH_PREDICT_EN
    task automatic test_predict();
        int ep; logic epred;
        do_reset();
        start_run(1'b1);
        tick();
        for (int k = 0; k < 15; k++) begin
            ep    = (k < 6) ? k : 3 + (k - 6) % 3;
            epred = (k >= 6) && ((k - 6) % 3 == 0);
            n_tests++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'(ep) ||
                bus.pred_taken_o !== epred || fault_o !== 1'b0) begin
                n_fail++;
                $display("FAIL pred_loop[%0d]: valid=%b ipc=%0d pred=%b fault=%b, required 1/%0d/%b/0",
                         k, bus.inst_valid_o, bus.inst_pc_o, bus.pred_taken_o, fault_o, ep, epred);
            end
            tick();
        end
    endtask
`else
    task automatic test_fault();
        bit hit = 0;
        do_reset();
        start_run(1'b1);
        for (int c = 0; c < 40 && !hit; c++) begin
            if (fault_o === 1'b1) hit = 1;
            else tick();
        end
        n_tests++;
        if (!hit || bus.pc_o !== 32'd16 || state_o !== 2'd3) begin
            n_fail++;
            $display("FAIL fault_entry: seen=%0d pc=%0d state=%0d, required 1/16/3", hit, bus.pc_o, state_o);
        end
        repeat (3) tick();
        n_tests++;
        if (bus.inst_valid_o !== 1'b0 || fault_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_drain: valid=%b fault=%b, required 0/1", bus.inst_valid_o, fault_o);
        end
        redirect_i = 1'b1; redirect_pc_i = 32'd3;
        tick();
        redirect_i = 1'b0;
        n_tests++;
        if (fault_o !== 1'b0 || state_o !== 2'd1 || bus.pc_o !== 32'd3) begin
            n_fail++;
            $display("FAIL fault_exit: fault=%b state=%0d pc=%0d, required 0/1/3", fault_o, state_o, bus.pc_o);
        end
        tick();
        n_tests++;
        if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'd3) begin
            n_fail++;
            $display("FAIL fault_refetch: valid=%b ipc=%0d, required 1/3", bus.inst_valid_o, bus.inst_pc_o);
        end
    endtask
`endif

    task automatic test_halt();
        logic [31:0] held;
        do_reset();
        start_run(1'b1);
        repeat (3) tick();
        held = bus.pc_o;
        halt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (state_o !== 2'd2 || bus.pc_o !== held || bus.inst_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: state=%0d pc=%0d valid=%b, required 2/%0d/0",
                         k, state_o, bus.pc_o, bus.inst_valid_o, held);
            end
        end
        halt_i = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (state_o !== 2'd1 || bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== held) begin
            n_fail++;
            $display("FAIL halt_resume: state=%0d valid=%b ipc=%0d, required 1/1/%0d",
                     state_o, bus.inst_valid_o, bus.inst_pc_o, held);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run(1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({state_o, fault_o, bus.inst_valid_o, bus.pred_taken_o} !== 5'd0 ||
            bus.pc_o !== 32'd0 || bus.inst_o !== 32'd0 || bus.inst_pc_o !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d valid=%b pc=%0d inst=%0h ipc=%0d, required all 0",
                     state_o, bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.inst_pc_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 3) == 0) mem[i] = {6'h04, 10'd0, 16'hFFFF - 16'($urandom_range(0, 3))};
            else mem[i][31:26] = 6'h01;
        end
        for (int c = 0; c < 400; c++) begin
            start_i          = ($urandom_range(0, 3) == 0);
            bus.inst_ready_i = ($urandom_range(0, 3) != 0);
            halt_i           = ($urandom_range(0, 9) == 0);
            redirect_i       = ($urandom_range(0, 15) == 0);
            redirect_pc_i    = 32'($urandom_range(0, 19));
            tick();
            n_tests++;
            if (bus.pc_o !== m_pc || state_o !== 2'(m_st) || fault_o !== (m_st == 3) ||
                bus.inst_valid_o !== (mq.size() > 0)) begin
                n_fail++; errs++;
                if (errs < 10)
                    $display("FAIL rand_ctrl@%0d: pc=%0d st=%0d valid=%b, required pc=%0d st=%0d valid=%b",
                             c, bus.pc_o, state_o, bus.inst_valid_o, m_pc, m_st, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_tests++;
                if (bus.inst_o !== mq[0].inst || bus.inst_pc_o !== mq[0].pc || bus.pred_taken_o !== mq[0].pred) begin
                    n_fail++; errs++;
                    if (errs < 10)
                        $display("FAIL rand_head@%0d: inst=%0h pc=%0d pred=%b, required %0h/%0d/%b",
                                 c, bus.inst_o, bus.inst_pc_o, bus.pred_taken_o, mq[0].inst, mq[0].pc, mq[0].pred);
                end
            end
        end
    endtask

    initial begin
        bus.inst_ready_i = 1'b0;
        load_prog();
        test_reset();
        test_program();
        test_backpressure();
        test_redirect();
`ifdef FETCH_PREDICT_EN
        test_predict();
`else
        test_fault();
`endif
        test_halt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the nemesys core. Owns the program counter and drives the combinational-read instruction memory. Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. Handles start, halt, branch redirect from execute, and out-of-range PC faults.

Parameters:
MEM_DEPTH, 16, number of instruction words; any PC >= MEM_DEPTH is out of range.
BOOT_PC, 0, PC loaded on reset and used on start.
BUF_DEPTH, 2, fetch queue entries; only the value 2 is supported.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  begin fetching from BOOT_PC; sampled only in IDLE.
halt_i  in  1  level; while high, no new fetches are made.
redirect_i  in  1  execute-stage branch taken; flush and reload PC.
redirect_pc_i  in  32  redirect target word address.
pc_o  out  32  word address to instruction memory; equals pc_q.
inst_i  in  `WIDTH  memory read data; valid in the same cycle as pc_o.
inst_o  out  `WIDTH  queue head instruction.
inst_pc_o  out  32  PC of the queue head.
inst_valid_o  out  1  queue non-empty.
inst_ready_i  in  1  decode accepts the head.
pred_taken_o  out  1  head was fetched down a predicted-taken path.
fault_o  out  1  high in the FAULT state.
state_o  out  2  current state, for debug.

Behaviour:
- States: IDLE=0, RUN=1, HALT=2, FAULT=3. Reset sets IDLE, pc_q=BOOT_PC, count=0, and all outputs to 0 except pc_o=BOOT_PC.
- IDLE -> RUN when start_i=1; pc_q is reloaded with BOOT_PC.
- RUN -> HALT when halt_i=1. HALT -> RUN when halt_i=0. The queue keeps draining in HALT.
- RUN -> FAULT when pc_q >= MEM_DEPTH. That out-of-range PC is never pushed. FAULT is left only by redirect_i (-> RUN) or reset.
- Fetch condition: state=RUN, halt_i=0, pc_q < MEM_DEPTH, redirect_i=0, and (count<2 or pop this cycle). On fetch, {inst_i, pc_q} is pushed and pc_q <= next_pc.
- next_pc = pc_q + 1, 32-bit, wrapping modulo 2^32 (unreachable in practice because of the fault check).
- Pop occurs when inst_valid_o and inst_ready_i are both high. Push and pop may occur in the same cycle; count is unchanged in that case.
- Outputs inst_o, inst_pc_o and pred_taken_o come combinationally from the queue head, so there is zero added latency after the entry is written. The first instruction becomes valid 1 cycle after start_i.
- redirect_i has the highest priority in every non-IDLE state:
  - count <= 0 and pc_q <= redirect_pc_i.
  - No push that cycle.
  - A simultaneous pop is accepted by the handshake, but the entry is flushed anyway; decode kills it.
  - Target validity is checked on the next cycle; an out-of-range target leads to FAULT.
- redirect_i in IDLE is ignored.
- halt_i and redirect_i together: redirect is applied and the state becomes HALT.
- Reset mid-operation clears the queue and returns to IDLE immediately, regardless of state.

Optional Feature:
FETCH_PREDICT_EN
- Defined:
  - Static backward-taken prediction. When the pushed word's opcode field equals `BR and imm16[15]=1, next_pc = pc_q + sign-extended imm16.
  - The entry is tagged pred=1 and exposed on pred_taken_o.
  - Execute then issues redirect_i only on mispredict.
- Undefined: next_pc is always pc_q+1, pred_taken_o is tied to 0, and no opcode decode logic is present.

Decomposition:
- defines.vh: `WIDTH, opcode constants (`BR), opcode field position, and the FETCH_* state encodings.
- One sub-module, fetch_buf: 2-entry FIFO of {inst, pc, pred} with push, pop, flush and count, holding no control policy.
- fetch_ctrl holds the state machine, PC and prediction logic.

Test Plan:
- Reset then start_i, with memory loaded with the 6-word MOV/MOV/MOV/ADD/CMP/BR program and inst_ready_i=1 -> inst_pc_o = 0,1,2,3,4,5 on consecutive cycles from cycle 1; no fault.
- inst_ready_i=0 for 5 cycles after start -> count saturates at 2, pc_q holds at 2, inst_pc_o stays 0. Ready released -> 0,1,2,3 with no gap and no duplicate.
- redirect_i with redirect_pc_i=3 while the queue holds PCs 4,5 -> next valid inst_pc_o=3, then 4; the flushed entries never reappear.
- Macro off, BR at PC 5 with no redirect -> pc_q reaches 16, fault_o=1 the next cycle, and the queue drains. A later redirect to 3 -> RUN with fault_o=0.
- FETCH_PREDICT_EN defined -> after PC 5 (BR #-2), the next fetched PC is 3 with pred_taken_o=1 on PC 3; the loop repeats indefinitely with no fault.
- halt_i pulsed 3 cycles mid-run -> no pushes during the halt, the queue drains, and fetch resumes at the held pc_q. rst_n asserted mid-run -> all outputs 0, pc_o=BOOT_PC, state IDLE asynchronously.
